// File: rtl/comparator_pkg.sv
// ---------------------------------------------------------------------------
// comparator_pkg
// Shared definitions for the serial magnitude comparator:
//   - FSM state constants and enum (IDLE / COMPARE)
//   - digit_count(): number of DIGIT-wide digits in a WIDTH-bit operand
//   - cnt_width():   width of the digit counter, minimum 1 bit
// ---------------------------------------------------------------------------
package comparator_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COMPARE = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = ST_IDLE,
    COMPARE = ST_COMPARE
  } state_e;

  // Number of digits scanned per operation.
  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must hold 0..d-1; a single digit still needs one bit.
  function automatic int cnt_width(input int d);
    if (d <= 2) begin
      return 1;
    end else begin
      return $clog2(d);
    end
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit.sv
// ---------------------------------------------------------------------------
// digit_comparator
// Combinational DIGIT-wide stage of the MSB-first greater/equal chain.
// Ports:
//   i_gt, i_eq : chain state from the more significant digits
//   da, db     : current digit of operand A and B
//   o_gt, o_eq : updated chain state
// ---------------------------------------------------------------------------
module digit_comparator #(
  parameter int DIGIT = 2
) (
  input  logic             i_gt,
  input  logic             i_eq,
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  output logic             o_gt,
  output logic             o_eq
);

  // Once a more significant digit has decided the order, lower digits are ignored.
  always_comb begin
    o_gt = i_gt | (i_eq & (da > db));
    o_eq = i_eq & (da == db);
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, with
// early termination at the first differing digit. Signed compares are done
// by flipping both MSBs and comparing unsigned.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : request a comparison (sampled only while idle)
//   signed_mode      : 1 = two's-complement compare (latched with start)
//   a, b             : operands (latched with start)
//   busy             : comparison in progress
//   done             : one-cycle pulse, result registers updated
//   o_gt, o_eq, o_lt : registered result, held until the next done or rst
// ---------------------------------------------------------------------------
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  localparam int D  = digit_count(WIDTH, DIGIT);
  localparam int CW = cnt_width(D);

  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             gt_r;
  logic             eq_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT-1:0] da_s;
  logic [DIGIT-1:0] db_s;
  logic             gt_s;
  logic             eq_s;
  logic             last_s;

  // Current digit is always the top of the shift registers.
  always_comb begin
    da_s = a_r[WIDTH-1 -: DIGIT];
    db_s = b_r[WIDTH-1 -: DIGIT];
  end

  digit_comparator #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_gt (gt_r),
    .i_eq (eq_r),
    .da   (da_s),
    .db   (db_s),
    .o_gt (gt_s),
    .o_eq (eq_s)
  );

  // Stop at the first difference or after the last digit; the counter never wraps.
  always_comb begin
    if (!eq_s || (cnt_r == CNT_LAST)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // FSM, operand shift registers, chain state, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      gt_r    <= 1'b0;
      eq_r    <= 1'b1;
      cnt_r   <= CNT_ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
      o_gt    <= 1'b0;
      o_eq    <= 1'b0;
      o_lt    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // MSB flip maps two's-complement order onto unsigned order.
            a_r     <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
            b_r     <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
            gt_r    <= 1'b0;
            eq_r    <= 1'b1;
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b1;
            state_r <= COMPARE;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        COMPARE: begin
          gt_r  <= gt_s;
          eq_r  <= eq_s;
          a_r   <= a_r << DIGIT;
          b_r   <= b_r << DIGIT;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_s) begin
            o_gt    <= gt_s;
            o_eq    <= eq_s;
            o_lt    <= ~gt_s & ~eq_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= COMPARE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_magnitude_comparator
// Self-checking bench: directed scenarios plus randomized operations checked
// against an arithmetic reference (signed/unsigned relational operators and
// first-differing-digit latency).
// ---------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

  localparam int W  = 8;
  localparam int DG = 2;
  localparam int D  = W / DG;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         o_gt;
  logic         o_eq;
  logic         o_lt;

  int n_checks;
  int n_errors;

  serial_magnitude_comparator #(
    .WIDTH (W),
    .DIGIT (DG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .o_gt        (o_gt),
    .o_eq        (o_eq),
    .o_lt        (o_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: order from plain relational operators, latency from the
  // index (1-based, MSB first) of the first digit where the operands differ.
  task automatic model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output logic eg, output logic ee, output logic el);
    logic [W-1:0] x;
    x   = av ^ bv;
    lat = D;
    for (int k = D; k >= 1; k--) begin
      if (x[W-1-(k-1)*DG -: DG] != '0) lat = k;
    end
    if (s) begin
      eg = $signed(av) > $signed(bv);
      el = $signed(av) < $signed(bv);
    end else begin
      eg = av > bv;
      el = av < bv;
    end
    ee = (av == bv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op at the next edge (called #1 after an edge) and waits for done.
  task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input string tag);
    int   exp_lat;
    int   lat;
    logic eg, ee, el;
    model(s, av, bv, exp_lat, eg, ee, el);
    start       = 1'b1;
    signed_mode = s;
    a           = av;
    b           = bv;
    tick();
    start       = 1'b0;
    a           = W'($urandom);
    b           = W'($urandom);
    signed_mode = 1'($urandom);
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_done0"}, done, 0);
    lat = 0;
    while (!done && lat < D + 3) begin
      tick();
      lat++;
      if (!done) chk({tag, "_busy_mid"}, busy, 1);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_gt"}, o_gt, eg);
    chk({tag, "_eq"}, o_eq, ee);
    chk({tag, "_lt"}, o_lt, el);
  endtask

  initial begin
    int           lat;
    int           extra_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {o_gt, o_eq, o_lt}, 0);
    rst = 1'b0;
    tick();

    // Equal operands, full scan; signed overflow cases; late difference.
    run_op(1'b0, 8'hA5, 8'hA5, "eq_a5");
    run_op(1'b0, 8'h80, 8'h7F, "u_80_7f");
    run_op(1'b1, 8'h80, 8'h7F, "s_80_7f");
    run_op(1'b0, 8'h34, 8'h37, "u_34_37");
    run_op(1'b1, 8'hFF, 8'hFE, "s_ff_fe");

    // Start while busy must be ignored.
    tick();
    start = 1'b1; a = 8'h10; b = 8'h20; signed_mode = 1'b0;
    tick();
    a = 8'hFF; b = 8'h00;
    tick();
    start = 1'b0;
    chk("ign_busy1", busy, 1);
    tick();
    chk("ign_done", done, 1);
    chk("ign_lt", {o_gt, o_eq, o_lt}, 3'b001);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) extra_done++;
    end
    chk("ign_no_second_done", extra_done, 0);
    chk("ign_hold_lt", {o_gt, o_eq, o_lt}, 3'b001);

    // Reset mid-compare aborts without a done pulse.
    start = 1'b1; a = 8'h01; b = 8'h02;
    tick();
    start = 1'b0;
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out", {done, o_gt, o_eq, o_lt}, 0);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) extra_done++;
    end
    chk("abort_no_done", extra_done, 0);

    // Back-to-back: second start lands in the done cycle of the first.
    run_op(1'b0, 8'h40, 8'h00, "b2b_first");
    run_op(1'b0, 8'h00, 8'h00, "b2b_second");

    // Randomized ops, biased toward equal and near-equal operands.
    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_op(1'($urandom), ra, rb, "rand");
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Multi-cycle magnitude comparator for two WIDTH-bit operands. It scans the operands MSB-first, DIGIT bits per cycle, through a chained greater/equal stage, and stops early at the first differing digit. Signed and unsigned modes are selectable per operation. It uses a start/busy/done handshake and sits in the datapath wherever an area-cheap comparison is preferred over a full-width combinational comparator.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits compared per cycle; must divide WIDTH exactly, otherwise elaboration fails. D = WIDTH/DIGIT digits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; sampled only while busy=0.
- signed_mode  in  1  1 = two's-complement compare; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse: result registers updated this cycle.
- o_gt  out  1  A > B.
- o_eq  out  1  A == B.
- o_lt  out  1  A < B.

## Operation
- States: IDLE, COMPARE.
- IDLE with start=1:
  - latch a, b, and signed_mode into shift registers;
  - when signed_mode=1, invert the MSB of both latched operands, so that an unsigned compare yields the signed order;
  - clear the chain state to gt=0, eq=1; set the digit counter to 0;
  - go to COMPARE.
- COMPARE, each cycle:
  - take the top DIGIT bits of each operand register;
  - update the chain: gt' = gt | (eq & (da > db)); eq' = eq & (da == db);
  - shift both registers left by DIGIT and increment the counter.
- Termination: when eq' = 0 or counter = D−1:
  - register o_gt = gt', o_eq = eq', o_lt = ~gt' & ~eq';
  - pulse done and return to IDLE.
- Exactly one of o_gt/o_eq/o_lt is 1 after the first done. The results hold until the next done or rst.
- start while busy=1 is ignored; no queuing.
- signed_mode, a, and b are don't-care except in the start cycle.
- Counter width is clog2(D), with a minimum of 1. It never wraps, because termination occurs at D−1.

## Timing
- Reset values: busy=0, done=0, o_gt=0, o_eq=0, o_lt=0; state IDLE.
- The edge that samples start=1 (edge 0) sets busy=1.
- Digit k (1..D) is evaluated at edge k. If it terminates, done=1 and busy=0 after edge k.
- Latency from the start edge to done is k cycles, where k is the index of the first differing digit, or D when the operands are equal. Minimum latency is 1, maximum is D.
- The done cycle has busy=0, so a start in that same cycle is accepted. Throughput is one operation per k+1 cycles (edge 0 plus k compare edges).
- rst=1 at any edge, including mid-COMPARE:
  - return to IDLE and clear all outputs to their reset values;
  - no done is produced for the aborted operation;
  - start is ignored during rst.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package comparator_pkg holds:
  - state enum (IDLE, COMPARE);
  - a helper function for the digit count (WIDTH/DIGIT) and the counter width.
- Sub-module digit_comparator: combinational, parameter DIGIT.
  - Inputs i_gt, i_eq, da, db; outputs o_gt, o_eq.
  - It is the DIGIT-wide chain stage and is instantiated once.
- The top level holds the FSM, the operand shift registers, the counter, and the result registers.

## Test plan
Defaults apply: WIDTH=8, DIGIT=2, D=4.

1. Unsigned, a=0xA5, b=0xA5, start → done exactly 4 cycles after the start edge; o_eq=1, o_gt=0, o_lt=0; busy high for cycles 1–3.
2. Unsigned, a=0x80, b=0x7F → done 1 cycle after start, o_gt=1. Signed, same operands → done 1 cycle after start, o_lt=1 (−128 < 127).
3. Unsigned, a=0x34, b=0x37 (first three digits equal) → done after 4 cycles, o_lt=1. Signed, a=0xFF, b=0xFE → o_gt=1 (−1 > −2), done after 4 cycles.
4. a=0x10, b=0x20 started, then start with a=0xFF, b=0x00 at cycle 1 while busy → second request ignored; done after 2 cycles with o_lt=1, and no second done follows.
5. Start with a=0x01, b=0x02, rst=1 at cycle 2 → after that edge busy=0 and all outputs 0; no done pulse within the next 6 cycles.
6. Back-to-back: start a=0x40, b=0x00; assert start with a=0x00, b=0x00 in the done cycle of the first → first result o_gt=1; second accepted immediately, done 4 cycles later with o_eq=1.
